// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared core defines for the pipeline stall/flush controller:
// hold-vector width, stall encodings, stage indices and FSM state encoding.
package pipe_stall_ctrl_pkg;

  localparam int StallBus = 6;

  typedef logic [StallBus-1:0] stall_vec_t;

  // Stage index of each bit in the hold vector
  localparam int STG_PC   = 0;
  localparam int STG_IFID = 1;
  localparam int STG_IDEX = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int STG_WB   = 5;

  // Hold-vector encodings: ID stall freezes PC..ID/EX, EX stall also EX/MEM
  localparam stall_vec_t STALL_NONE = 6'b000000;
  localparam stall_vec_t STALL_ID   = 6'b000111;
  localparam stall_vec_t STALL_EX   = 6'b001111;

  // FSM state encoding, kept as plain constants for legacy compatibility
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MC_RUN = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // Load-use stall contribution from decode
  function automatic stall_vec_t id_stall(input logic stallreq_id);
    return stallreq_id ? STALL_ID : STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the datapath and the stall controller.
// master = pipeline side (raises requests), slave = controller.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 6
);
  import pipe_stall_ctrl_pkg::*;

  logic             stallreq_id;
  logic             mc_start;
  logic [CNT_W-1:0] mc_cycles;
  logic             flush_req;
  stall_vec_t       stall_o;
  logic             flush_o;
  logic             mc_busy_o;
  logic             mc_done_o;

  modport master (
    output stallreq_id, mc_start, mc_cycles, flush_req,
    input  stall_o, flush_o, mc_busy_o, mc_done_o
  );

  modport slave (
    input  stallreq_id, mc_start, mc_cycles, flush_req,
    output stall_o, flush_o, mc_busy_o, mc_done_o
  );

endinterface

// File: rtl/pipe_stall_ctrl_stall_cnt.sv
// Loadable down-counter with zero flag, shared by the multi-cycle and
// flush sequencing of pipe_stall_ctrl.
module stall_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Load has priority over decrement; reset clears the count
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - CNT_W'(1);
  end

  // Zero flag used by the FSM to detect the last cycle
  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall and flush controller: merges load-use and multi-cycle EX
// stalls into the per-stage hold vector and sequences multi-cycle flushes.
// Outputs are combinational so stalls take effect in the requesting cycle.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W     = 6,
  parameter int FLUSH_LEN = 1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD =
    (FLUSH_LEN >= 2) ? CNT_W'(FLUSH_LEN - 2) : '0;

  logic [1:0]       state, next_state;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt;

  stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state, counter control and output decode; flush > multi-cycle > load-use
  always_comb begin
    next_state    = state;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_load_val  = '0;
    bus.stall_o   = STALL_NONE;
    bus.flush_o   = 1'b0;
    bus.mc_busy_o = 1'b0;
    bus.mc_done_o = 1'b0;

    if (rst) begin
      next_state = ST_IDLE;
    end else if (bus.flush_req) begin
      bus.flush_o  = 1'b1;
      cnt_load     = 1'b1;
      cnt_load_val = FLUSH_RELOAD;
      next_state   = (FLUSH_LEN >= 2) ? ST_FLUSH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.mc_start && (bus.mc_cycles >= CNT_W'(2))) begin
            bus.stall_o   = STALL_EX;
            bus.mc_busy_o = 1'b1;
            cnt_load      = 1'b1;
            cnt_load_val  = bus.mc_cycles - CNT_W'(2);
            next_state    = ST_MC_RUN;
          end else if (bus.mc_start) begin
            bus.mc_done_o = 1'b1;
            bus.stall_o   = id_stall(bus.stallreq_id);
          end else begin
            bus.stall_o   = id_stall(bus.stallreq_id);
          end
        end
        ST_MC_RUN: begin
          bus.mc_busy_o = 1'b1;
          if (!cnt_zero) begin
            bus.stall_o = STALL_EX;
            cnt_dec     = 1'b1;
          end else begin
            bus.mc_done_o = 1'b1;
            bus.stall_o   = id_stall(bus.stallreq_id);
            next_state    = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          bus.flush_o = 1'b1;
          if (cnt_zero) next_state = ST_IDLE;
          else          cnt_dec    = 1'b1;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (FLUSH_LEN 1 and 3) share the
// stimulus; a cycle-count model pushes expectations, a monitor compares.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(6)) bus1 ();
  pipe_stall_ctrl_if #(.CNT_W(6)) bus3 ();

  pipe_stall_ctrl #(.CNT_W(6), .FLUSH_LEN(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  pipe_stall_ctrl #(.CNT_W(6), .FLUSH_LEN(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    int         u;
    string      tag;
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_err    = 0;

  // Model state per unit: remaining EX cycles of the op (incl. current), remaining flush cycles
  int m_mc[2];
  int m_fl[2];
  int fls[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int u, input string tag, input logic r, input logic sid,
                       input logic ms, input logic [5:0] n, input logic fr);
    exp_t e;
    e.u = u; e.tag = tag;
    e.stall = 6'b000000; e.flush = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    if (r) begin
      m_mc[u] = 0;
      m_fl[u] = 0;
    end else if (fr) begin
      e.flush = 1'b1;
      m_mc[u] = 0;
      m_fl[u] = fls[u] - 1;
    end else if (m_fl[u] > 0) begin
      e.flush = 1'b1;
      m_fl[u]--;
    end else if (m_mc[u] > 0) begin
      e.busy = 1'b1;
      if (m_mc[u] > 1) begin
        e.stall = 6'b001111;
        m_mc[u]--;
      end else begin
        e.done  = 1'b1;
        e.stall = sid ? 6'b000111 : 6'b000000;
        m_mc[u] = 0;
      end
    end else if (ms && n >= 2) begin
      e.stall = 6'b001111;
      e.busy  = 1'b1;
      m_mc[u] = int'(n) - 1;
    end else if (ms) begin
      e.done  = 1'b1;
      e.stall = sid ? 6'b000111 : 6'b000000;
    end else begin
      e.stall = sid ? 6'b000111 : 6'b000000;
    end
    sbq.push_back(e);
  endtask

  // Drive one cycle of stimulus to both instances and record expectations
  task automatic step(input string tag, input logic r, input logic sid,
                      input logic ms, input logic [5:0] n, input logic fr);
    @(posedge clk);
    #1;
    rst = r;
    bus1.stallreq_id = sid; bus1.mc_start = ms; bus1.mc_cycles = n; bus1.flush_req = fr;
    bus3.stallreq_id = sid; bus3.mc_start = ms; bus3.mc_cycles = n; bus3.flush_req = fr;
    model(0, tag, r, sid, ms, n, fr);
    model(1, tag, r, sid, ms, n, fr);
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  // Compare DUT outputs mid-cycle against queued expectations
  always begin : monitor
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.u == 0) got = {bus1.stall_o, bus1.flush_o, bus1.mc_busy_o, bus1.mc_done_o};
      else          got = {bus3.stall_o, bus3.flush_o, bus3.mc_busy_o, bus3.mc_done_o};
      check($sformatf("%s.u%0d.stall", e.tag, e.u), 32'(got[8:3]), 32'(e.stall));
      check($sformatf("%s.u%0d.flush", e.tag, e.u), 32'(got[2]),   32'(e.flush));
      check($sformatf("%s.u%0d.busy",  e.tag, e.u), 32'(got[1]),   32'(e.busy));
      check($sformatf("%s.u%0d.done",  e.tag, e.u), 32'(got[0]),   32'(e.done));
    end
  end

  initial begin
    fls[0] = 1; fls[1] = 3;
    m_mc[0] = 0; m_mc[1] = 0; m_fl[0] = 0; m_fl[1] = 0;
    bus1.stallreq_id = 1'b0; bus1.mc_start = 1'b0; bus1.mc_cycles = '0; bus1.flush_req = 1'b0;
    bus3.stallreq_id = 1'b0; bus3.mc_start = 1'b0; bus3.mc_cycles = '0; bus3.flush_req = 1'b0;

    // Reset forces outputs low regardless of requests
    step("rst_sid",  1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    step("rst_all",  1'b1, 1'b1, 1'b1, 6'd5, 1'b1);
    step("rst_hold", 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);

    // Load-use stall for exactly one cycle
    step("ld_use",   1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    idle("ld_clr", 2);

    // DIV N=5
    step("div5", 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    idle("div5_run", 6);

    // Degenerate lengths, then N=2
    step("n1", 1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
    idle("n1_after", 1);
    step("n0", 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    idle("n0_after", 1);
    step("n2", 1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
    idle("n2_run", 3);

    // Flush mid-op: N=10 at T, flush at T+3
    step("mc10", 1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
    idle("mc10_run", 2);
    step("mc10_fl", 1'b0, 1'b1, 1'b0, 6'd0, 1'b1);
    idle("mc10_after", 12);

    // Back-to-back flush, mc_start at T+2
    step("fl_a",  1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    step("fl_b",  1'b0, 1'b1, 1'b0, 6'd0, 1'b1);
    step("fl_ms", 1'b0, 1'b1, 1'b1, 6'd4, 1'b0);
    idle("fl_after", 6);

    // Flush beats a simultaneous mc_start
    step("fl_vs_ms", 1'b0, 1'b0, 1'b1, 6'd7, 1'b1);
    idle("fl_vs_ms_after", 5);

    // Load-use on the done cycle, and mc_start + load-use together in IDLE
    step("ov_ms", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
    step("ov_run", 1'b0, 1'b1, 1'b1, 6'd9, 1'b0);
    step("ov_done", 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    step("ms_sid", 1'b0, 1'b1, 1'b1, 6'd3, 1'b0);
    idle("ms_sid_run", 3);

    // Reset mid-op and mid-flush: no done pulse afterwards
    step("rmc_ms", 1'b0, 1'b0, 1'b1, 6'd6, 1'b0);
    idle("rmc_run", 1);
    step("rmc_rst", 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    idle("rmc_after", 7);
    step("rfl_fl", 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    step("rfl_rst", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    idle("rfl_after", 3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0),
           6'($urandom_range(0, 12)),
           ($urandom_range(0, 14) == 0));
    end
    idle("tail", 2);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
